// File: rtl/xz_operand_mux_pipe_pkg.sv
// Shared select encodings and helpers for the X/Z operand-select stage.
package xz_mux_pkg;

    localparam logic [2:0] SEL_IN0  = 3'b000;
    localparam logic [2:0] SEL_IN1  = 3'b001;
    localparam logic [2:0] SEL_IN2  = 3'b010;
    localparam logic [2:0] SEL_IN3  = 3'b011;
    localparam logic [2:0] SEL_ZERO = 3'b100;

    // Codes 101..111 are reserved; they behave like SEL_ZERO on the data path.
    function automatic logic is_reserved_sel(input logic [2:0] sel);
        return sel[2] & (sel[1] | sel[0]);
    endfunction

endpackage

// File: rtl/xz_operand_mux_pipe_ext.sv
// Combinational zero/sign extender from W_IN bits up to W_OUT bits.
module operand_ext #(
    parameter int W_IN   = 48,
    parameter int W_OUT  = 48,
    parameter bit SIGNED = 1'b0
) (
    input  logic [W_IN-1:0]  din,
    output logic [W_OUT-1:0] dout
);

    generate
        if (W_IN < 1 || W_IN > W_OUT) begin : g_bad_width
            $error("operand_ext: W_IN (%0d) must be in 1..W_OUT (%0d)", W_IN, W_OUT);
            assign dout = '0;
        end else if (W_IN == W_OUT) begin : g_same_width
            assign dout = din;
        end else begin : g_extend
            logic fill;
            assign fill = SIGNED ? din[W_IN-1] : 1'b0;
            assign dout = {{(W_OUT - W_IN){fill}}, din};
        end
    endgenerate

endmodule

// File: rtl/xz_operand_mux_pipe.sv
// Registered operand-select stage: extend four operands, mux one (or zero),
// and carry it with a valid bit through a 1- or 2-stage clock-enabled pipeline.
module xz_operand_mux_pipe
    import xz_mux_pkg::*;
#(
    parameter int         WIDTH_OUT   = 48,
    parameter int         W_IN0       = 48,
    parameter int         W_IN1       = 48,
    parameter int         W_IN2       = 36,
    parameter int         W_IN3       = 1,
    parameter logic [3:0] SIGN_EXT    = 4'b0100,
    parameter int         PIPE_STAGES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic [W_IN0-1:0]     in0,
    input  logic [W_IN1-1:0]     in1,
    input  logic [W_IN2-1:0]     in2,
    input  logic [W_IN3-1:0]     in3,
    input  logic [2:0]           sel,
    input  logic                 in_valid,
    input  logic                 sel_err_clr,
    output logic [WIDTH_OUT-1:0] out,
    output logic                 out_valid,
    output logic                 sel_err
);

    generate
        if (PIPE_STAGES != 1 && PIPE_STAGES != 2) begin : g_bad_pipe
            $error("xz_operand_mux_pipe: PIPE_STAGES (%0d) must be 1 or 2", PIPE_STAGES);
        end
    endgenerate

    logic [WIDTH_OUT-1:0] ext0, ext1, ext2, ext3;
    logic [WIDTH_OUT-1:0] mux_data;

    operand_ext #(.W_IN(W_IN0), .W_OUT(WIDTH_OUT), .SIGNED(SIGN_EXT[0])) u_ext0 (.din(in0), .dout(ext0));
    operand_ext #(.W_IN(W_IN1), .W_OUT(WIDTH_OUT), .SIGNED(SIGN_EXT[1])) u_ext1 (.din(in1), .dout(ext1));
    operand_ext #(.W_IN(W_IN2), .W_OUT(WIDTH_OUT), .SIGNED(SIGN_EXT[2])) u_ext2 (.din(in2), .dout(ext2));
    operand_ext #(.W_IN(W_IN3), .W_OUT(WIDTH_OUT), .SIGNED(SIGN_EXT[3])) u_ext3 (.din(in3), .dout(ext3));

    always_comb begin
        mux_data = '0;
        case (sel)
            SEL_IN0: mux_data = ext0;
            SEL_IN1: mux_data = ext1;
            SEL_IN2: mux_data = ext2;
            SEL_IN3: mux_data = ext3;
            default: mux_data = '0;
        endcase
    end

    logic [WIDTH_OUT-1:0] s1_data_d, s1_data_q;
    logic                 s1_vld_d,  s1_vld_q;
    logic                 sel_err_d, sel_err_q;

    // Data is captured even without in_valid; the valid bit alone qualifies it.
    // A set in the same cycle as a clear takes priority.
    always_comb begin
        s1_data_d = s1_data_q;
        s1_vld_d  = s1_vld_q;
        sel_err_d = sel_err_q;
        if (ce) begin
            s1_data_d = mux_data;
            s1_vld_d  = in_valid;
            if (sel_err_clr) begin
                sel_err_d = 1'b0;
            end
            if (in_valid && is_reserved_sel(sel)) begin
                sel_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
            sel_err_q <= 1'b0;
        end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    generate
        if (PIPE_STAGES == 2) begin : g_pipe2
            logic [WIDTH_OUT-1:0] s2_data_d, s2_data_q;
            logic                 s2_vld_d,  s2_vld_q;

            always_comb begin
                s2_data_d = s2_data_q;
                s2_vld_d  = s2_vld_q;
                if (ce) begin
                    s2_data_d = s1_data_q;
                    s2_vld_d  = s1_vld_q;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_data_q <= '0;
                    s2_vld_q  <= 1'b0;
                end else begin
                    s2_data_q <= s2_data_d;
                    s2_vld_q  <= s2_vld_d;
                end
            end

            assign out       = s2_data_q;
            assign out_valid = s2_vld_q;
        end else begin : g_pipe1
            assign out       = s1_data_q;
            assign out_valid = s1_vld_q;
        end
    endgenerate

endmodule
